arith_share_arb: RTL and testbench



---
 rtl/arith_share_arb.sv | 157 +++++++++++++++
 tb/tb_arith_share_arb.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/arith_share_arb.sv
// rtl/arith_share_arb.sv - two-requester round-robin arbiter/sequencer for the shared arithmetic unit
//
// Accepts one op at a time from req0/req1 (tie -> requester not granted last),
// holds it in EXEC for its latency (mul: MUL_CYC, others: 1), then presents a
// tagged result on the rsp_* channel until rsp_ready.
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   reqN_valid/ready/op/a/b       request channels (op: 00 add, 01 sub, 10 mul, 11 reserved)
//   rsp_valid/ready/id/data       response channel, id = issuing requester
//   rsp_lsbx, rsp_err             product[0]^addsub[0]; reserved-op flag
//   busy, ops_done                not idle; completed response handshakes (wraps)
module arith_share_arb #(
   parameter int W       = 16,
   parameter int MUL_CYC = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           req0_valid,
   output logic           req0_ready,
   input  logic [1:0]     req0_op,
   input  logic [W-1:0]   req0_a,
   input  logic [W-1:0]   req0_b,
   input  logic           req1_valid,
   output logic           req1_ready,
   input  logic [1:0]     req1_op,
   input  logic [W-1:0]   req1_a,
   input  logic [W-1:0]   req1_b,
   output logic           rsp_valid,
   input  logic           rsp_ready,
   output logic           rsp_id,
   output logic [2*W-1:0] rsp_data,
   output logic           rsp_lsbx,
   output logic           rsp_err,
   output logic           busy,
   output logic [15:0]    ops_done
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_MUL = 2'b10;
   localparam logic [1:0] OP_RSV = 2'b11;

   state_t           state_q, state_d;
   logic             last_grant_q, last_grant_d;
   logic [3:0]       cnt_q, cnt_d;
   logic [1:0]       op_q;
   logic [W-1:0]     a_q, b_q;
   logic             id_q;
   logic [2*W-1:0]   rsp_data_q;
   logic             rsp_lsbx_q, rsp_err_q;
   logic [15:0]      ops_done_q, ops_done_d;

   logic             grant1, accept, load_result;
   logic [1:0]       sel_op;
   logic [W-1:0]     sel_a, sel_b;
   logic [W-1:0]     addsub;
   logic [2*W-1:0]   product, result;

   // Requester 1 wins only if alone or if requester 0 was served last.
   // Readies are gated with rst_n so they read 0 while reset is held.
   assign grant1     = req1_valid && (!req0_valid || !last_grant_q);
   assign req1_ready = rst_n && (state_q == IDLE) && grant1;
   assign req0_ready = rst_n && (state_q == IDLE) && req0_valid && !grant1;
   assign accept     = req0_ready || req1_ready;

   assign sel_op = req1_ready ? req1_op : req0_op;
   assign sel_a  = req1_ready ? req1_a  : req0_a;
   assign sel_b  = req1_ready ? req1_b  : req0_b;

   // Subtract is ones'-complement: a + ~b with no carry-in.
   assign addsub  = a_q + ((op_q == OP_SUB) ? ~b_q : b_q);
   assign product = {{W{1'b0}}, a_q} * {{W{1'b0}}, b_q};

   always_comb begin
      result = '0;
      case (op_q)
         OP_MUL:  result = product;
         OP_RSV:  result = '0;
         default: result = {{W{1'b0}}, addsub};
      endcase
   end

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      cnt_d        = cnt_q;
      ops_done_d   = ops_done_q;
      load_result  = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               last_grant_d = req1_ready;
               cnt_d        = (sel_op == OP_MUL) ? 4'(MUL_CYC - 1) : 4'd0;
               state_d      = EXEC;
            end
         end
         EXEC: begin
            if (cnt_q == 4'd0) begin
               load_result = 1'b1;
               state_d     = RESP;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               ops_done_d = ops_done_q + 16'd1;
               state_d    = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b1;
         cnt_q        <= '0;
         ops_done_q   <= '0;
         op_q         <= '0;
         a_q          <= '0;
         b_q          <= '0;
         id_q         <= 1'b0;
         rsp_data_q   <= '0;
         rsp_lsbx_q   <= 1'b0;
         rsp_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         cnt_q        <= cnt_d;
         ops_done_q   <= ops_done_d;
         if (accept) begin
            op_q <= sel_op;
            a_q  <= sel_a;
            b_q  <= sel_b;
            id_q <= req1_ready;
         end
         if (load_result) begin
            rsp_data_q <= result;
            rsp_lsbx_q <= (a_q[0] & b_q[0]) ^ addsub[0];
            rsp_err_q  <= (op_q == OP_RSV);
         end
      end
   end

   // Result fields are held at 0 outside RESP so the channel is quiet when idle.
   assign rsp_valid = (state_q == RESP);
   assign rsp_id    = rsp_valid ? id_q       : 1'b0;
   assign rsp_data  = rsp_valid ? rsp_data_q : '0;
   assign rsp_lsbx  = rsp_valid ? rsp_lsbx_q : 1'b0;
   assign rsp_err   = rsp_valid ? rsp_err_q  : 1'b0;
   assign busy      = (state_q != IDLE);
   assign ops_done  = ops_done_q;

endmodule

// File: tb/tb_arith_share_arb.sv
// tb/tb_arith_share_arb.sv - scoreboard bench for arith_share_arb
module tb_arith_share_arb;
   localparam int W       = 16;
   localparam int MUL_CYC = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          req0_valid = 1'b0, req1_valid = 1'b0;
   logic          req0_ready, req1_ready;
   logic [1:0]    req0_op = '0, req1_op = '0;
   logic [W-1:0]  req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
   logic          rsp_valid, rsp_ready, rsp_id, rsp_lsbx, rsp_err, busy;
   logic [2*W-1:0] rsp_data;
   logic [15:0]   ops_done;

   arith_share_arb #(.W(W), .MUL_CYC(MUL_CYC)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
      .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
      .req1_a(req1_a), .req1_b(req1_b),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_data(rsp_data), .rsp_lsbx(rsp_lsbx), .rsp_err(rsp_err),
      .busy(busy), .ops_done(ops_done)
   );

   always #5 clk = ~clk;

   typedef struct { logic [1:0] op; logic [15:0] a; logic [15:0] b; } req_t;
   typedef struct { logic id; logic [31:0] data; logic lsbx; logic err; int due; } exp_t;

   req_t drv_q0[$], drv_q1[$];
   int   rd0 = 0, rd1 = 0;
   exp_t sb[$];
   logic hs0 = 1'b0, hs1 = 1'b0;
   logic m_free = 1'b1, m_last = 1'b1;
   logic [15:0] m_done = '0;
   int   cyc = 0;
   int   rdy_mode = 0;   // 0: always ready, 1: stall, 2: random
   int   errors = 0, checks = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   // Reference: plain unsigned arithmetic on the operands.
   function automatic exp_t model(input logic id, input req_t r, input int now);
      exp_t e;
      int unsigned ai, bi, bsel;
      ai   = r.a;
      bi   = r.b;
      bsel = (r.op == 2'd1) ? (32'd65535 - bi) : bi;
      e.id  = id;
      e.err = (r.op == 2'd3);
      case (r.op)
         2'd0:    e.data = (ai + bi) % 32'd65536;
         2'd1:    e.data = (ai + bsel) % 32'd65536;
         2'd2:    e.data = ai * bi;
         default: e.data = 32'd0;
      endcase
      e.lsbx = ((ai % 2) & (bi % 2)) != ((ai + bsel) % 2);
      e.due  = now + ((r.op == 2'd2) ? MUL_CYC : 1) + 1;
      return e;
   endfunction

   // Requester stability while waiting for ready.
   a_stable0: assert property (@(posedge clk) disable iff (!rst_n)
      (req0_valid && !req0_ready) |=> (!req0_valid || $stable({req0_op, req0_a, req0_b})))
      else $error("req0 changed while waiting");
   a_stable1: assert property (@(posedge clk) disable iff (!rst_n)
      (req1_valid && !req1_ready) |=> (!req1_valid || $stable({req1_op, req1_a, req1_b})))
      else $error("req1 changed while waiting");

   // Drivers: present the next queued op and hold it until the handshake.
   initial forever begin
      @(posedge clk); #1;
      if (req0_valid && hs0) req0_valid = 1'b0;
      if (!req0_valid && rd0 < drv_q0.size()) begin
         req0_op = drv_q0[rd0].op; req0_a = drv_q0[rd0].a; req0_b = drv_q0[rd0].b;
         rd0++;
         req0_valid = 1'b1;
      end
   end
   initial forever begin
      @(posedge clk); #1;
      if (req1_valid && hs1) req1_valid = 1'b0;
      if (!req1_valid && rd1 < drv_q1.size()) begin
         req1_op = drv_q1[rd1].op; req1_a = drv_q1[rd1].a; req1_b = drv_q1[rd1].b;
         rd1++;
         req1_valid = 1'b1;
      end
   end

   initial begin
      rsp_ready = 1'b1;
      forever begin
         @(posedge clk); #1;
         case (rdy_mode)
            0:       rsp_ready = 1'b1;
            1:       rsp_ready = 1'b0;
            default: rsp_ready = ($urandom % 2) == 0;
         endcase
      end
   end

   // Monitor / scoreboard.
   initial forever begin
      logic e0, e1, rv, nfree;
      req_t r;
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
         check("reset_outputs",
               {9'd0, rsp_valid, req0_ready, req1_ready, busy, rsp_id, rsp_lsbx, rsp_err,
                ops_done, rsp_data}, 64'd0);
         sb.delete();
         m_free = 1'b1; m_last = 1'b1; m_done = '0;
         hs0 = 1'b0; hs1 = 1'b0;
      end else begin
         nfree = 1'b0;
         e1 = m_free && req1_valid && (!req0_valid || !m_last);
         e0 = m_free && req0_valid && !e1;
         check("req0_ready", req0_ready, e0);
         check("req1_ready", req1_ready, e1);
         check("busy", busy, !m_free);
         check("ops_done", ops_done, m_done);
         rv = (sb.size() > 0) && (cyc >= sb[0].due);
         check("rsp_valid", rsp_valid, rv);
         if (rsp_valid && rv) begin
            check("rsp_id", rsp_id, sb[0].id);
            check("rsp_data", rsp_data, sb[0].data);
            check("rsp_lsbx", rsp_lsbx, sb[0].lsbx);
            check("rsp_err", rsp_err, sb[0].err);
            if (rsp_ready) begin
               void'(sb.pop_front());
               m_done = m_done + 16'd1;
               nfree = 1'b1;
            end
         end
         hs0 = req0_valid && req0_ready;
         hs1 = req1_valid && req1_ready;
         if (e0 || e1) begin
            if (e1) begin r.op = req1_op; r.a = req1_a; r.b = req1_b; end
            else    begin r.op = req0_op; r.a = req0_a; r.b = req0_b; end
            sb.push_back(model(e1, r, cyc));
            m_last = e1;
            m_free = 1'b0;
         end
         if (nfree) m_free = 1'b1;
      end
   end

   task automatic push(input int n, input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
      req_t r;
      r.op = op; r.a = a; r.b = b;
      if (n == 0) drv_q0.push_back(r); else drv_q1.push_back(r);
   endtask

   task automatic wait_idle(input int budget);
      int n;
      n = 0;
      while (!(rd0 == drv_q0.size() && rd1 == drv_q1.size() && !req0_valid && !req1_valid
               && sb.size() == 0 && m_free) && n < budget) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      if (n >= budget) begin
         checks++; errors++;
         $display("FAIL wait_idle: timeout after %0d cycles, pending=%0d", n, sb.size());
      end
   endtask

   task automatic wait_sig(input string name, input int which, input int budget);
      int n;
      n = 0;
      while (((which == 0) ? !rsp_valid : !busy) && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (n >= budget) begin
         checks++; errors++;
         $display("FAIL %s: timeout after %0d cycles", name, n);
      end
   endtask

   function automatic logic [15:0] rnd_operand();
      case ($urandom % 4)
         0:       return 16'h0000;
         1:       return 16'hFFFF;
         default: return 16'($urandom);
      endcase
   endfunction

   initial begin
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // add and sub, carry drop
      @(negedge clk);
      push(0, 2'b00, 16'h0003, 16'h0005);
      wait_idle(50);
      push(1, 2'b01, 16'h0005, 16'h0003);
      wait_idle(50);
      push(1, 2'b00, 16'hFFFF, 16'h0001);
      wait_idle(50);

      // tie right after reset: req0 first, then req1, repeat tie goes to req0 again
      @(posedge clk); #1 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      push(0, 2'b10, 16'hFFFF, 16'hFFFF);
      push(1, 2'b00, 16'h0002, 16'h0002);
      wait_idle(100);
      push(0, 2'b10, 16'h1234, 16'h00FF);
      push(1, 2'b01, 16'h0000, 16'h0000);
      wait_idle(100);

      // response stall with the other requester pending
      rdy_mode = 1;
      @(negedge clk);
      push(0, 2'b00, 16'h00F0, 16'h000F);
      wait_sig("stall_rsp_valid", 0, 50);
      push(1, 2'b01, 16'h0010, 16'h0001);
      repeat (3) @(negedge clk);
      rdy_mode = 0;
      wait_idle(100);

      // reserved op
      push(0, 2'b11, 16'h0001, 16'h0001);
      wait_idle(50);

      // reset in EXEC cycle 2 of a multiply, with req1 pending across the reset
      push(0, 2'b10, 16'h0101, 16'h0202);
      wait_sig("mul_busy", 1, 50);
      push(1, 2'b00, 16'h0007, 16'h0009);
      @(posedge clk); #1 rst_n = 1'b0;
      @(posedge clk); #1 rst_n = 1'b1;
      wait_idle(100);

      // randomized traffic with random backpressure
      rdy_mode = 2;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (($urandom % 3) == 0 && (drv_q0.size() - rd0) < 3)
            push(0, 2'($urandom), rnd_operand(), rnd_operand());
         if (($urandom % 3) == 0 && (drv_q1.size() - rd1) < 3)
            push(1, 2'($urandom), rnd_operand(), rnd_operand());
      end
      rdy_mode = 0;
      wait_idle(3000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
